keccak_sponge_ctrl: RTL

//  Rate-generic Keccak/SHA-3 sponge controller for SHA3-224/256/384/512 digest sizes.
//  - Absorbs 64-bit message words and pads in-line.
//  - XORs each word into a 1600-bit state register.
//  - Drives an external f-permutation over a start/done handshake.
//  - Presents the byte-reordered digest.
//  New versus the fixed 512-bit top: selectable digest size and pad byte, an

---
 rtl/keccak_sponge_ctrl.sv | 78 +++++++
 1 files changed

// File: rtl/keccak_sponge_ctrl.sv
// keccak_sponge_ctrl: SHA-3 sponge controller that absorbs 64-bit words with in-line padding,
// drives an external Keccak-f[1600] over start/done and presents the byte-reordered digest.
module keccak_sponge_ctrl #(
   parameter int         OUT_BITS = 512,
   parameter logic [7:0] PAD_BYTE = 8'h01
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [63:0]         in,
   input  logic                in_ready,
   input  logic                is_last,
   input  logic [2:0]          byte_num,
   output logic                ack,
   output logic [1599:0]       perm_in,
   output logic                perm_start,
   input  logic [1599:0]       perm_out,
   input  logic                perm_done,
   output logic [OUT_BITS-1:0] out,
   output logic                out_ready,
   input  logic                out_ack
);
   localparam int RATE_W = (1600 - 2 * OUT_BITS) / 64;
   localparam int OUT_W  = (OUT_BITS + 63) / 64;
   typedef enum logic [1:0] {ABSORB, PSTART, PWAIT, SQUEEZE} state_t;
   state_t              r_fsm, w_fsm_nxt;
   logic [1599:0]       r_state, w_mix;
   logic [4:0]          r_wcnt;
   logic                r_last_seen;
   logic [63:0]         w_word;
   logic [64*OUT_W-1:0] w_x;

   always_comb begin
      ack = reset && in_ready && r_fsm == ABSORB;
      perm_start = r_fsm == PSTART;
      out_ready = r_fsm == SQUEEZE;
      perm_in = r_state;
      w_word = is_last ? (in & ~(64'hFFFF_FFFF_FFFF_FFFF >> {byte_num, 3'b000}))
                         | ({56'd0, PAD_BYTE} << (7'd56 - {1'b0, byte_num, 3'b000})) : in;
      w_mix = '0;
      for (int k = 0; k < RATE_W; k++)
         if (r_wcnt == 5'(k)) w_mix[1599-64*k -: 64] = w_word;
      // final-bit 0x80 OR-combines with the pad byte when both land in the last rate byte
      if (is_last) w_mix[1600-64*RATE_W +: 8] = w_mix[1600-64*RATE_W +: 8] | 8'h80;
      w_x = '0;
      for (int i = 0; i < OUT_W; i++)
         for (int b = 0; b < 8; b++)
            w_x[64*(OUT_W-i)-1-8*b -: 8] = r_state[1599-64*i-8*(7-b) -: 8];
      out = w_x[64*OUT_W-1 -: OUT_BITS];
      w_fsm_nxt = r_fsm;
      case (r_fsm)
         ABSORB:  w_fsm_nxt = (ack && (is_last || r_wcnt == 5'(RATE_W-1))) ? PSTART : ABSORB;
         PSTART:  w_fsm_nxt = PWAIT;
         PWAIT:   w_fsm_nxt = perm_done ? (r_last_seen ? SQUEEZE : ABSORB) : PWAIT;
         default: w_fsm_nxt = out_ack ? ABSORB : SQUEEZE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_fsm <= ABSORB;
         r_state <= '0;
         r_wcnt <= '0;
         r_last_seen <= 1'b0;
      end else begin
         r_fsm <= w_fsm_nxt;
         if (ack) begin
            r_state <= r_state ^ w_mix;
            r_wcnt <= (is_last || r_wcnt == 5'(RATE_W-1)) ? 5'd0 : r_wcnt + 5'd1;
            r_last_seen <= r_last_seen | is_last;
         end else if (r_fsm == PWAIT && perm_done) begin
            r_state <= perm_out;
         end else if (r_fsm == SQUEEZE && out_ack) begin
            r_state <= '0;
            r_last_seen <= 1'b0;
         end
      end
   end
endmodule
